// File: rtl/peripheral_uart_ahb3_master_ctrl.sv
// AHB3-Lite master that programs a 16550-style UART behind an AHB-to-APB
// bridge, then streams bytes into THR after polling LSR.THRE.
module peripheral_uart_ahb3_master_ctrl #(
    parameter int          HADDR_SIZE = 32,
    parameter int          HDATA_SIZE = 32,
    parameter logic [31:0] UART_BASE  = 32'h0,
    parameter logic [15:0] DIVISOR    = 16'd27,
    parameter logic [7:0]  LCR_VAL    = 8'h03,
    parameter logic [7:0]  IER_VAL    = 8'h00,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  start_i,
    input  logic                  tx_valid_i,
    input  logic [7:0]            tx_data_i,
    output logic                  tx_ready_o,
    output logic                  cfg_done_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic                  timeout_o,
    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [HADDR_SIZE-1:0] BASE = HADDR_SIZE'(UART_BASE);
    localparam logic [7:0] OFF_THR = 8'h00;
    localparam logic [7:0] OFF_IER = 8'h04;
    localparam logic [7:0] OFF_FCR = 8'h08;
    localparam logic [7:0] OFF_LCR = 8'h0C;
    localparam logic [7:0] OFF_LSR = 8'h14;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_A,
        S_CFG_D,
        S_RUN,
        S_POLL_A,
        S_POLL_D,
        S_WR_A,
        S_WR_D
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [PW-1:0]           poll_q, poll_d;
    logic [7:0]              byte_q, byte_d;
    logic [1:0]              trans_q, trans_d;
    logic                    sel_q, sel_d;
    logic [HADDR_SIZE-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [HDATA_SIZE-1:0]   wdata_q, wdata_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    tmo_q, tmo_d;
    logic                    ready_q, ready_d;

    logic                    launch;
    logic [7:0]              l_off;
    logic                    l_wr;
    logic [7:0]              l_data;
    logic                    unused_rdata;

    assign unused_rdata = ^{HRDATA[HDATA_SIZE-1:6], HRDATA[4:0]};

    // {register offset, write data} for each step of the bring-up sequence
    function automatic logic [15:0] cfg_entry(input logic [2:0] idx);
        unique case (idx)
            3'd0:    cfg_entry = {OFF_LCR, 8'h80 | LCR_VAL};
            3'd1:    cfg_entry = {OFF_THR, DIVISOR[7:0]};
            3'd2:    cfg_entry = {OFF_IER, DIVISOR[15:8]};
            3'd3:    cfg_entry = {OFF_LCR, LCR_VAL};
            3'd4:    cfg_entry = {OFF_FCR, 8'h07};
            default: cfg_entry = {OFF_IER, IER_VAL};
        endcase
    endfunction

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            poll_q  <= '0;
            byte_q  <= '0;
            trans_q <= TR_IDLE;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            byte_q  <= byte_d;
            trans_q <= trans_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        poll_d  = poll_q;
        byte_d  = byte_q;
        trans_d = trans_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        ready_d = 1'b0;
        launch  = 1'b0;
        l_off   = OFF_THR;
        l_wr    = 1'b0;
        l_data  = 8'h00;

        unique case (state_q)
            S_IDLE, S_RUN: begin
                if (start_i) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    poll_d  = '0;
                    idx_d   = '0;
                    {l_off, l_data} = cfg_entry(3'd0);
                    l_wr    = 1'b1;
                    launch  = 1'b1;
                    state_d = S_CFG_A;
                end else if (state_q == S_RUN && tx_valid_i && !ready_q) begin
                    // the cycle tx_ready_o is high still shows the consumed byte
                    byte_d  = tx_data_i;
                    l_off   = OFF_LSR;
                    launch  = 1'b1;
                    state_d = S_POLL_A;
                end
            end
            S_CFG_A, S_POLL_A, S_WR_A: begin
                if (HREADY) begin
                    trans_d = TR_IDLE;
                    sel_d   = 1'b0;
                    state_d = state_t'(state_q + 3'd1);
                end
            end
            S_CFG_D: begin
                if (HREADY) begin
                    if (HRESP) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (idx_q == 3'd5) begin
                        done_d  = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        {l_off, l_data} = cfg_entry(idx_q + 3'd1);
                        l_wr    = 1'b1;
                        launch  = 1'b1;
                        state_d = S_CFG_A;
                    end
                end
            end
            S_POLL_D: begin
                if (HREADY) begin
                    if (HRESP) begin
                        err_d   = 1'b1;
                        poll_d  = '0;
                        state_d = S_IDLE;
                    end else if (HRDATA[5]) begin
                        l_off   = OFF_THR;
                        l_wr    = 1'b1;
                        l_data  = byte_q;
                        launch  = 1'b1;
                        state_d = S_WR_A;
                    end else if (poll_q == PW'(POLL_LIMIT - 1)) begin
                        tmo_d   = 1'b1;
                        poll_d  = '0;
                        state_d = S_RUN;
                    end else begin
                        poll_d  = poll_q + 1'b1;
                        l_off   = OFF_LSR;
                        launch  = 1'b1;
                        state_d = S_POLL_A;
                    end
                end
            end
            S_WR_D: begin
                if (HREADY) begin
                    poll_d = '0;
                    if (HRESP) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ready_d = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            trans_d = TR_NONSEQ;
            sel_d   = 1'b1;
            addr_d  = BASE + HADDR_SIZE'(l_off);
            write_d = l_wr;
            wdata_d = HDATA_SIZE'(l_data);
        end
    end

    assign HTRANS     = trans_q;
    assign HSEL       = sel_q;
    assign HADDR      = addr_q;
    assign HWRITE     = write_q;
    assign HWDATA     = wdata_q;
    assign HSIZE      = 3'b000;
    assign HBURST     = 3'b000;
    assign HPROT      = 4'b0011;
    assign HMASTLOCK  = 1'b0;
    assign tx_ready_o = ready_q;
    assign cfg_done_o = done_q;
    assign err_o      = err_q;
    assign timeout_o  = tmo_q;
    assign busy_o     = (state_q != S_IDLE) && (state_q != S_RUN);

endmodule

// File: tb/tb_peripheral_uart_ahb3_master_ctrl.sv
// Bench for peripheral_uart_ahb3_master_ctrl: AHB slave model with wait
// states, LSR busy injection and a transfer-level reference model.
module tb_peripheral_uart_ahb3_master_ctrl;

    localparam int PL = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        start_i = 1'b0;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_data_i = 8'h00;
    logic        tx_ready_o, cfg_done_o, busy_o, err_o, timeout_o;
    logic        HSEL, HWRITE, HMASTLOCK;
    logic [31:0] HADDR, HWDATA;
    logic [31:0] HRDATA = 32'h0;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    peripheral_uart_ahb3_master_ctrl #(.POLL_LIMIT(PL)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start_i(start_i),
        .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i),
        .tx_ready_o(tx_ready_o), .cfg_done_o(cfg_done_o),
        .busy_o(busy_o), .err_o(err_o), .timeout_o(timeout_o),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  data;
    } xfer_t;

    typedef struct {
        logic [7:0] b;
        int         busy;
        int         lat;
        bit         rdy;
        bit         to;
    } vec_t;

    xfer_t got[$];
    xfer_t exp_q[$];
    xfer_t pend;
    bit    pend_v = 0, pend_first = 0, prev_a = 0;
    logic [31:0] pend_wd, pa;
    logic  pw;
    int    wcnt = 0, wait_n = 0, wait_pct = 0, err_at = -1;
    int    busy_left = 0, ready_cnt = 0, unstable = 0, proto_err = 0;
    bit    stall_thr = 0;
    int    n_pass = 0, n_total = 0;

    // slave model: drives the response for the current cycle and logs transfers
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            pend_v = 0; prev_a = 0; wcnt = 0;
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        end else begin
            bit a_v, rdy, thre;
            if (tx_ready_o) ready_cnt++;
            a_v = HSEL && (HTRANS == 2'b10);
            rdy = 1;
            if (pend_v || a_v) begin
                rdy = (wcnt >= wait_n) && ($urandom_range(0, 99) >= wait_pct);
                if (pend_v && pend.wr && pend.addr == 32'h0 && stall_thr)
                    rdy = 0;
            end
            HREADY = rdy; HRESP = 1'b0; HRDATA = 32'h0;
            if (pend_v) begin
                if (a_v || HTRANS != 2'b00 || HSEL) proto_err++;
                if (pend_first) pend_wd = HWDATA;
                else if (HWDATA != pend_wd) unstable++;
                pend_first = 0;
                if (rdy) begin
                    if (!pend.wr && pend.addr == 32'h14) begin
                        thre = (busy_left == 0);
                        if (busy_left > 0) busy_left--;
                        HRDATA = thre ? ($urandom | 32'h20) : ($urandom & ~32'h20);
                    end
                    if (got.size() == err_at) HRESP = 1'b1;
                    if (pend.wr && HWDATA[31:8] != 0) proto_err++;
                    got.push_back({pend.addr, pend.wr,
                                   pend.wr ? HWDATA[7:0] : HRDATA[7:0]});
                    pend_v = 0; wcnt = 0;
                end else wcnt++;
            end else if (a_v) begin
                if (HSIZE != 0 || HBURST != 0 || HPROT != 4'b0011 || HMASTLOCK)
                    proto_err++;
                if (prev_a && (HADDR != pa || HWRITE != pw)) unstable++;
                pa = HADDR; pw = HWRITE;
                if (rdy) begin
                    pend_v = 1; pend_first = 1; prev_a = 0; wcnt = 0;
                    pend.addr = HADDR; pend.wr = HWRITE; pend.data = 8'h0;
                end else begin
                    prev_a = 1; wcnt++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_cfg(input int n);
        logic [31:0] a [6];
        logic [7:0]  d [6];
        a = '{32'h0C, 32'h00, 32'h04, 32'h0C, 32'h08, 32'h04};
        d = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};
        for (int i = 0; i < n; i++) exp_q.push_back({a[i], 1'b1, d[i]});
    endtask

    // reference: THRE appears after 'busy' not-ready LSR reads
    function automatic bit add_byte(input logic [7:0] b, input int busy);
        int reads = (busy < PL) ? busy + 1 : PL;
        for (int i = 0; i < reads; i++) exp_q.push_back({32'h14, 1'b0, 8'h00});
        if (busy < PL) exp_q.push_back({32'h00, 1'b1, b});
        return busy >= PL;
    endfunction

    task automatic compare_log(input string name);
        check({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), got[i].addr, exp_q[i].addr);
            check($sformatf("%s_wr%0d", name, i), got[i].wr, exp_q[i].wr);
            if (exp_q[i].wr)
                check($sformatf("%s_data%0d", name, i), got[i].data, exp_q[i].data);
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic run_cfg(output int lat, output logic [1:0] tr1,
                           output logic e1);
        @(negedge HCLK);
        start_i = 1'b1;
        lat = 0; tr1 = 2'b00; e1 = 1'b1;
        do begin
            @(negedge HCLK);
            start_i = 1'b0;
            lat++;
            if (lat == 1) begin tr1 = HTRANS; e1 = err_o; end
        end while (!cfg_done_o && !err_o && lat < 400);
        if (lat >= 400) check("cfg_bound", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int busy, input bit keep,
                             output int lat, output bit rdy, output bit to);
        busy_left = busy;
        tx_valid_i = 1'b1;
        tx_data_i = b;
        lat = 0; rdy = 0; to = 0;
        do begin
            @(negedge HCLK);
            lat++;
            rdy = tx_ready_o;
            to = timeout_o;
        end while (!rdy && !to && lat < 400);
        if (lat >= 400) check("send_bound", 0, 1);
        if (!keep) tx_valid_i = 1'b0;
    endtask

    vec_t vt [6];
    int lat, r0, exp_rdy;
    logic [1:0] tr1;
    logic e1;
    bit rdy, to, eto;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{8'h55, 0, 5, 1'b1, 1'b0};
        vt[1] = '{8'hA3, 0, 5, 1'b1, 1'b0};
        vt[2] = '{8'h00, 1, 7, 1'b1, 1'b0};
        vt[3] = '{8'hFF, 3, 11, 1'b1, 1'b0};
        vt[4] = '{8'h3C, 4, 9, 1'b0, 1'b1};
        vt[5] = '{8'h81, 9, 9, 1'b0, 1'b1};

        #2 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_hsel", HSEL, 0);
        check("rst_haddr", HADDR, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_status", {HWRITE, cfg_done_o, busy_o, err_o, timeout_o, tx_ready_o}, 0);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // zero-wait configuration
        push_cfg(6);
        run_cfg(lat, tr1, e1);
        check("cfg_latency", lat, 13);
        check("cfg_nonseq_c1", tr1, 2'b10);
        check("cfg_done", cfg_done_o, 1);
        check("cfg_busy_off", busy_o, 0);
        compare_log("cfg");

        // back-to-back bytes: second must not repeat the first
        r0 = ready_cnt;
        void'(add_byte(8'h55, 0));
        void'(add_byte(8'hA3, 0));
        send_byte(8'h55, 0, 1, lat, rdy, to);
        check("b2b_lat0", lat, 5);
        send_byte(8'hA3, 0, 0, lat, rdy, to);
        check("b2b_lat1", lat, 6);
        repeat (3) @(negedge HCLK);
        check("b2b_ready_cnt", ready_cnt - r0, 2);
        compare_log("b2b");

        // table vectors: busy polls, latency and timeout
        r0 = ready_cnt; exp_rdy = 0;
        foreach (vt[i]) begin
            eto = add_byte(vt[i].b, vt[i].busy);
            if (!eto) exp_rdy++;
            send_byte(vt[i].b, vt[i].busy, 0, lat, rdy, to);
            check($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            check($sformatf("vec%0d_rdy", i), rdy, vt[i].rdy);
            check($sformatf("vec%0d_to", i), to, vt[i].to);
            if (to) begin
                check($sformatf("vec%0d_run_idle", i), {busy_o, HTRANS}, 0);
                push_cfg(6);
                run_cfg(lat, tr1, e1);
                check($sformatf("vec%0d_to_clr", i), {timeout_o, cfg_done_o}, 2'b01);
            end
            repeat (2) @(negedge HCLK);
        end
        check("vec_ready_cnt", ready_cnt - r0, exp_rdy);
        compare_log("vec");

        // HRESP on the 3rd configuration write, then a clean restart
        err_at = 2;
        push_cfg(3);
        run_cfg(lat, tr1, e1);
        check("err_lat", lat, 7);
        check("err_flag", err_o, 1);
        check("err_no_done", cfg_done_o, 0);
        check("err_idle", {busy_o, HSEL, HTRANS}, 0);
        compare_log("err");
        err_at = -1;
        push_cfg(6);
        run_cfg(lat, tr1, e1);
        check("err_clr_c1", e1, 0);
        check("rerun_done", {cfg_done_o, err_o}, 2'b10);
        compare_log("rerun");

        // three wait states in every phase
        wait_n = 3;
        push_cfg(6);
        run_cfg(lat, tr1, e1);
        check("ws_cfg_lat", lat, 49);
        void'(add_byte(8'h5A, 1));
        send_byte(8'h5A, 1, 0, lat, rdy, to);
        check("ws_byte_lat", lat, 25);
        compare_log("ws");
        check("ws_stable", unstable, 0);
        wait_n = 0;
        repeat (2) @(negedge HCLK);

        // randomized bytes, busy polls and wait states
        wait_pct = 25;
        r0 = ready_cnt; exp_rdy = 0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            int bz;
            b = 8'($urandom);
            bz = $urandom_range(0, 5);
            eto = add_byte(b, bz);
            if (!eto) exp_rdy++;
            send_byte(b, bz, 0, lat, rdy, to);
            check($sformatf("rnd%0d_outcome", i), {rdy, to}, eto ? 2'b01 : 2'b10);
            if (to) begin
                push_cfg(6);
                run_cfg(lat, tr1, e1);
            end
            repeat (2) @(negedge HCLK);
        end
        check("rnd_ready_cnt", ready_cnt - r0, exp_rdy);
        compare_log("rnd");
        wait_pct = 0;

        // asynchronous reset in the middle of a THR data phase
        stall_thr = 1;
        busy_left = 0;
        tx_valid_i = 1'b1;
        tx_data_i = 8'hC7;
        lat = 0;
        do begin
            @(negedge HCLK);
            lat++;
        end while (!(pend_v && pend.wr && pend.addr == 32'h0) && lat < 100);
        check("thr_phase_reached", lat < 100, 1);
        r0 = ready_cnt;
        #2 HRESETn = 1'b0;
        #1;
        check("arst_htrans", {HSEL, HTRANS}, 0);
        check("arst_addr_data", {HADDR, HWDATA}, 0);
        check("arst_status", {HWRITE, cfg_done_o, busy_o, err_o, timeout_o, tx_ready_o}, 0);
        tx_valid_i = 1'b0;
        stall_thr = 0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (20) @(negedge HCLK);
        check("arst_no_ready", ready_cnt - r0, 0);
        check("arst_idle", {cfg_done_o, busy_o, HTRANS}, 0);
        check("protocol", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
